// File: rtl/mkey_press.sv
`default_nettype none
// ============================================================================
// mkey_press: per-channel key debouncer and short/double/long press classifier
// Revision: 1.0
// ============================================================================
module mkey_press #(
    parameter int   NCH       = 4,
    parameter logic ISH       = 1'b0,
    parameter int   TICK_DIV  = 1,
    parameter int   CHECKTIME = 3,
    parameter int   LONGTIME  = 30,
    parameter int   DBLGAP    = 25,
    parameter int   OUTKEEP   = 2
) (
    input  logic             clk_100,
    input  logic             rst_n,
    input  logic [NCH-1:0]   keyin,
    output logic [2*NCH-1:0] keyout,
    output logic [NCH-1:0]   key_evt,
    output logic [NCH-1:0]   key_level
);

    localparam int DBW = $clog2(CHECKTIME + 1);
    localparam int HDW = $clog2(LONGTIME + 1);
    localparam int GPW = (DBLGAP > 0) ? $clog2(DBLGAP + 1) : 1;
    localparam int OKW = (OUTKEEP > 0) ? $clog2(OUTKEEP + 1) : 1;

    localparam logic [DBW-1:0] C_CHECK_M1 = DBW'(CHECKTIME - 1);
    localparam logic [HDW-1:0] C_LONG     = HDW'(LONGTIME);
    localparam logic [GPW-1:0] C_GAP      = GPW'(DBLGAP);
    localparam logic [OKW-1:0] C_KEEP     = OKW'(OUTKEEP);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HELD   = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_SECOND = 3'd3;
    localparam logic [2:0] S_LWAIT  = 3'd4;

    localparam logic [1:0] EV_NONE   = 2'b00;
    localparam logic [1:0] EV_SHORT  = 2'b01;
    localparam logic [1:0] EV_DOUBLE = 2'b10;
    localparam logic [1:0] EV_LONG   = 2'b11;

    logic tick;

    generate
        if (TICK_DIV <= 1) begin : g_tick_every
            assign tick = 1'b1;
        end else begin : g_tick_div
            localparam int TW = $clog2(TICK_DIV);
            localparam logic [TW-1:0] C_TLAST = TW'(TICK_DIV - 1);
            logic [TW-1:0] pre_q;
            logic [TW-1:0] pre_d;

            always_comb begin
                pre_d = (pre_q == C_TLAST) ? '0 : pre_q + TW'(1);
            end

            always_ff @(posedge clk_100 or negedge rst_n) begin
                if (!rst_n) begin
                    pre_q <= '0;
                end else begin
                    pre_q <= pre_d;
                end
            end

            assign tick = (pre_q == C_TLAST);
        end
    endgenerate

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            logic [1:0]     sync_q;
            logic           level_q;
            logic           level_d;
            logic [DBW-1:0] db_q;
            logic [DBW-1:0] db_d;
            logic [2:0]     state_q;
            logic [2:0]     state_d;
            logic [HDW-1:0] hold_q;
            logic [HDW-1:0] hold_d;
            logic [GPW-1:0] gap_q;
            logic [GPW-1:0] gap_d;
            logic [OKW-1:0] keep_q;
            logic [OKW-1:0] keep_d;
            logic [1:0]     code_q;
            logic [1:0]     code_d;
            logic           evt_q;

            logic           pressed;
            logic           toggle;
            logic           rise;
            logic           fall;
            logic [HDW-1:0] hold_inc;
            logic [GPW-1:0] gap_inc;
            logic [OKW-1:0] keep_inc;
            logic           hold_reach;
            logic           gap_reach;
            logic           emit;
            logic [1:0]     emit_code;

            assign pressed = ISH ? sync_q[1] : ~sync_q[1];

            // Level flips only after CHECKTIME consecutive disagreeing ticks.
            always_comb begin
                db_d   = db_q;
                toggle = 1'b0;
                if (tick) begin
                    if (pressed == level_q) begin
                        db_d = '0;
                    end else if (db_q >= C_CHECK_M1) begin
                        db_d   = '0;
                        toggle = 1'b1;
                    end else begin
                        db_d = db_q + DBW'(1);
                    end
                end
            end

            assign level_d = level_q ^ toggle;
            assign rise    = toggle & ~level_q;
            assign fall    = toggle & level_q;

            assign hold_inc   = (hold_q == C_LONG) ? hold_q : hold_q + HDW'(1);
            assign gap_inc    = (gap_q == C_GAP) ? gap_q : gap_q + GPW'(1);
            assign keep_inc   = (keep_q == C_KEEP) ? keep_q : keep_q + OKW'(1);
            assign hold_reach = tick && (hold_inc == C_LONG);
            assign gap_reach  = tick && (gap_inc == C_GAP);

            always_ff @(posedge clk_100 or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q  <= {2{~ISH}};
                    level_q <= 1'b0;
                    db_q    <= '0;
                    state_q <= S_IDLE;
                    hold_q  <= '0;
                    gap_q   <= '0;
                    keep_q  <= '0;
                    code_q  <= EV_NONE;
                    evt_q   <= 1'b0;
                end else begin
                    sync_q  <= {sync_q[0], keyin[c]};
                    level_q <= level_d;
                    db_q    <= db_d;
                    state_q <= state_d;
                    hold_q  <= hold_d;
                    gap_q   <= gap_d;
                    keep_q  <= keep_d;
                    code_q  <= code_d;
                    evt_q   <= emit;
                end
            end

            // A long threshold reached on the release clk still reports LONG,
            // but returns straight to IDLE since no further release will come.
            always_comb begin
                state_d = state_q;
                hold_d  = hold_q;
                gap_d   = gap_q;
                case (state_q)
                    S_IDLE: begin
                        if (rise) begin
                            state_d = S_HELD;
                            hold_d  = '0;
                        end
                    end
                    S_HELD: begin
                        if (tick) hold_d = hold_inc;
                        if (hold_reach) begin
                            state_d = fall ? S_IDLE : S_LWAIT;
                        end else if (fall) begin
                            if (DBLGAP == 0) begin
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_GAP;
                                gap_d   = '0;
                            end
                        end
                    end
                    S_GAP: begin
                        if (tick) gap_d = gap_inc;
                        if (rise) begin
                            state_d = S_SECOND;
                            hold_d  = '0;
                        end else if (gap_reach) begin
                            state_d = S_IDLE;
                        end
                    end
                    S_SECOND: begin
                        if (tick) hold_d = hold_inc;
                        if (hold_reach) begin
                            state_d = fall ? S_IDLE : S_LWAIT;
                        end else if (fall) begin
                            state_d = S_IDLE;
                        end
                    end
                    S_LWAIT: begin
                        if (fall) state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end

            always_comb begin
                emit      = 1'b0;
                emit_code = EV_NONE;
                case (state_q)
                    S_HELD: begin
                        if (hold_reach) begin
                            emit      = 1'b1;
                            emit_code = EV_LONG;
                        end else if (fall && (DBLGAP == 0)) begin
                            emit      = 1'b1;
                            emit_code = EV_SHORT;
                        end
                    end
                    S_GAP: begin
                        if (!rise && gap_reach) begin
                            emit      = 1'b1;
                            emit_code = EV_SHORT;
                        end
                    end
                    S_SECOND: begin
                        if (hold_reach) begin
                            emit      = 1'b1;
                            emit_code = EV_LONG;
                        end else if (fall) begin
                            emit      = 1'b1;
                            emit_code = EV_DOUBLE;
                        end
                    end
                    default: begin
                        emit      = 1'b0;
                        emit_code = EV_NONE;
                    end
                endcase
            end

            // A new emit overwrites the held code and restarts the hold time.
            always_comb begin
                code_d = code_q;
                keep_d = keep_q;
                if (emit) begin
                    code_d = emit_code;
                    keep_d = '0;
                end else if (code_q != EV_NONE) begin
                    if (OUTKEEP == 0) begin
                        code_d = EV_NONE;
                    end else if (tick) begin
                        keep_d = keep_inc;
                        if (keep_inc == C_KEEP) begin
                            code_d = EV_NONE;
                            keep_d = '0;
                        end
                    end
                end
            end

            assign keyout[2*c +: 2] = code_q;
            assign key_evt[c]       = evt_q;
            assign key_level[c]     = level_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mkey_press.sv
`default_nettype none
// ============================================================================
// tb_mkey_press: directed and random checks of mkey_press against a timing model
// Revision: 1.0
// ============================================================================
module tb_mkey_press;

    localparam int   NCH  = 4;
    localparam logic ISH  = 1'b0;
    localparam int   CHK  = 3;
    localparam int   LNG  = 30;
    localparam int   GAP  = 25;
    localparam int   KEEP = 2;

    logic             clk;
    logic             rst_n;
    logic [NCH-1:0]   keyin;
    logic [2*NCH-1:0] keyout;
    logic [NCH-1:0]   key_evt;
    logic [NCH-1:0]   key_level;

    int errors = 0;
    int checks = 0;

    mkey_press #(
        .NCH(NCH), .ISH(ISH), .TICK_DIV(1), .CHECKTIME(CHK),
        .LONGTIME(LNG), .DBLGAP(GAP), .OUTKEEP(KEEP)
    ) dut (
        .clk_100  (clk),
        .rst_n    (rst_n),
        .keyin    (keyin),
        .keyout   (keyout),
        .key_evt  (key_evt),
        .key_level(key_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NCH-1:0] raw(input logic [NCH-1:0] pressed_mask);
        return ISH ? pressed_mask : ~pressed_mask;
    endfunction

    // Reference model: debounce by run length, classify by elapsed time since edges.
    // mode: 0 idle, 1 first press, 2 awaiting second press, 3 second press, 4 long done
    logic [2*NCH-1:0] m_code;
    logic [NCH-1:0]   m_evt;
    logic [NCH-1:0]   m_lvl;
    logic [NCH-1:0]   m_s1, m_s2;
    int m_run[NCH], m_mode[NCH], m_mark[NCH], m_clr[NCH];
    int now;
    logic m_pr, m_rise, m_fall;
    logic [1:0] m_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now    = 0;
            m_code = '0;
            m_evt  = '0;
            m_lvl  = '0;
            m_s1   = {NCH{~ISH}};
            m_s2   = {NCH{~ISH}};
            for (int c = 0; c < NCH; c++) begin
                m_run[c] = 0; m_mode[c] = 0; m_mark[c] = 0; m_clr[c] = -1;
            end
        end else begin
            now++;
            for (int c = 0; c < NCH; c++) begin
                m_pr    = ISH ? m_s2[c] : ~m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = keyin[c];
                m_rise  = 1'b0;
                m_fall  = 1'b0;
                if (m_pr != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == CHK) begin
                        m_run[c] = 0;
                        m_rise   = m_pr;
                        m_fall   = ~m_pr;
                        m_lvl[c] = m_pr;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_e = 2'b00;
                case (m_mode[c])
                    0: if (m_rise) begin m_mode[c] = 1; m_mark[c] = now; end
                    1: begin
                        if (now - m_mark[c] == LNG) begin
                            m_e = 2'b11; m_mode[c] = m_fall ? 0 : 4;
                        end else if (m_fall) begin
                            if (GAP == 0) begin m_e = 2'b01; m_mode[c] = 0; end
                            else begin m_mode[c] = 2; m_mark[c] = now; end
                        end
                    end
                    2: begin
                        if (m_rise) begin m_mode[c] = 3; m_mark[c] = now; end
                        else if (now - m_mark[c] == GAP) begin m_e = 2'b01; m_mode[c] = 0; end
                    end
                    3: begin
                        if (now - m_mark[c] == LNG) begin
                            m_e = 2'b11; m_mode[c] = m_fall ? 0 : 4;
                        end else if (m_fall) begin
                            m_e = 2'b10; m_mode[c] = 0;
                        end
                    end
                    default: if (m_fall) m_mode[c] = 0;
                endcase
                m_evt[c] = (m_e != 2'b00);
                if (m_e != 2'b00) begin
                    m_code[2*c +: 2] = m_e;
                    m_clr[c] = now + ((KEEP == 0) ? 1 : KEEP);
                end else if (now == m_clr[c]) begin
                    m_code[2*c +: 2] = 2'b00;
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        keyin = raw('0);
        repeat (3) @(negedge clk);
        checks++;
        if (keyout !== '0) begin
            errors++; $display("FAIL reset_keyout got=%h want=0", keyout);
        end
        checks++;
        if (key_evt !== '0) begin
            errors++; $display("FAIL reset_evt got=%b want=0", key_evt);
        end
        checks++;
        if (key_level !== '0) begin
            errors++; $display("FAIL reset_level got=%b want=0", key_level);
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if ({keyout, key_evt, key_level} !== {m_code, m_evt, m_lvl}) begin
                errors++;
                $display("FAIL reset_idle got=%h/%b/%b want=%h/%b/%b",
                         keyout, key_evt, key_level, m_code, m_evt, m_lvl);
            end
        end
    endtask

    task automatic test_bounce();
        int lvl_hi = 0;
        int evts = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            checks++;
            if ({keyout, key_evt, key_level} !== {m_code, m_evt, m_lvl}) begin
                errors++;
                $display("FAIL bounce_model i=%0d got=%h/%b/%b want=%h/%b/%b",
                         i, keyout, key_evt, key_level, m_code, m_evt, m_lvl);
            end
            if (key_level[0]) lvl_hi++;
            if (key_evt[0]) evts++;
            keyin = raw((i < 40 && (i % 4) < 2) ? 4'b0001 : 4'b0000);
        end
        checks++;
        if (lvl_hi != 0 || evts != 0) begin
            errors++; $display("FAIL bounce_quiet got level_hi=%0d evts=%0d want 0/0", lvl_hi, evts);
        end
    endtask

    task automatic test_short();
        int rise_at = -1, fall_at = -1, evt_at = -1, clr_at = -1, evts = 0;
        logic [1:0] code_at_evt = 2'b00;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            checks++;
            if ({keyout, key_evt, key_level} !== {m_code, m_evt, m_lvl}) begin
                errors++;
                $display("FAIL short_model i=%0d got=%h/%b/%b want=%h/%b/%b",
                         i, keyout, key_evt, key_level, m_code, m_evt, m_lvl);
            end
            if (key_level[1] && rise_at < 0) rise_at = i;
            if (!key_level[1] && rise_at >= 0 && fall_at < 0) fall_at = i;
            if (key_evt[1]) begin
                evts++;
                if (evt_at < 0) begin evt_at = i; code_at_evt = keyout[3:2]; end
            end
            if (evt_at >= 0 && clr_at < 0 && keyout[3:2] == 2'b00) clr_at = i;
            keyin = raw((i < 10) ? 4'b0010 : 4'b0000);
        end
        checks++;
        if (rise_at != 2 + CHK) begin
            errors++; $display("FAIL short_rise got=%0d want=%0d", rise_at, 2 + CHK);
        end
        checks++;
        if (evt_at != 10 + 2 + CHK + GAP || code_at_evt !== 2'b01) begin
            errors++;
            $display("FAIL short_emit got at=%0d code=%b want at=%0d code=01",
                     evt_at, code_at_evt, 10 + 2 + CHK + GAP);
        end
        checks++;
        if (evt_at - fall_at != GAP || evts != 1) begin
            errors++; $display("FAIL short_gap got=%0d evts=%0d want=%0d evts=1", evt_at - fall_at, evts, GAP);
        end
        checks++;
        if (clr_at - evt_at != KEEP) begin
            errors++; $display("FAIL short_keep got=%0d want=%0d", clr_at - evt_at, KEEP);
        end
    endtask

    task automatic test_double();
        int falls = 0, evt_at = -1, fall2_at = -1, evts = 0, shorts = 0;
        logic prev = 1'b0;
        logic [1:0] code_at_evt = 2'b00;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            checks++;
            if ({keyout, key_evt, key_level} !== {m_code, m_evt, m_lvl}) begin
                errors++;
                $display("FAIL double_model i=%0d got=%h/%b/%b want=%h/%b/%b",
                         i, keyout, key_evt, key_level, m_code, m_evt, m_lvl);
            end
            if (prev && !key_level[0]) begin
                falls++;
                if (falls == 2) fall2_at = i;
            end
            prev = key_level[0];
            if (keyout[1:0] == 2'b01) shorts++;
            if (key_evt[0]) begin
                evts++;
                if (evt_at < 0) begin evt_at = i; code_at_evt = keyout[1:0]; end
            end
            keyin = raw((i < 8 || (i >= 18 && i < 26)) ? 4'b0001 : 4'b0000);
        end
        checks++;
        if (evt_at != fall2_at || fall2_at != 26 + 2 + CHK || code_at_evt !== 2'b10) begin
            errors++;
            $display("FAIL double_emit got at=%0d fall2=%0d code=%b want at=%0d code=10",
                     evt_at, fall2_at, code_at_evt, 26 + 2 + CHK);
        end
        checks++;
        if (shorts != 0 || evts != 1) begin
            errors++; $display("FAIL double_only got shorts=%0d evts=%0d want 0/1", shorts, evts);
        end
    endtask

    task automatic test_long();
        int evt_at = -1, evts = 0;
        logic [1:0] code_at_evt = 2'b00;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({keyout, key_evt, key_level} !== {m_code, m_evt, m_lvl}) begin
                errors++;
                $display("FAIL long_model i=%0d got=%h/%b/%b want=%h/%b/%b",
                         i, keyout, key_evt, key_level, m_code, m_evt, m_lvl);
            end
            if (key_evt[2]) begin
                evts++;
                if (evt_at < 0) begin evt_at = i; code_at_evt = keyout[5:4]; end
            end
            keyin = raw((i < 50) ? 4'b0100 : 4'b0000);
        end
        checks++;
        if (evt_at != 2 + CHK + LNG || code_at_evt !== 2'b11 || evts != 1) begin
            errors++;
            $display("FAIL long_emit got at=%0d code=%b evts=%0d want at=%0d code=11 evts=1",
                     evt_at, code_at_evt, evts, 2 + CHK + LNG);
        end
    endtask

    task automatic test_concurrency();
        int both_at = -1;
        logic [7:0] out_at = '0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if ({keyout, key_evt, key_level} !== {m_code, m_evt, m_lvl}) begin
                errors++;
                $display("FAIL conc_model i=%0d got=%h/%b/%b want=%h/%b/%b",
                         i, keyout, key_evt, key_level, m_code, m_evt, m_lvl);
            end
            if (key_evt[0] && key_evt[3] && both_at < 0) begin
                both_at = i; out_at = keyout;
            end
            keyin = raw({(i < 50), 2'b00, (i < 5)});
        end
        checks++;
        if (both_at != 2 + CHK + LNG || out_at[1:0] !== 2'b01 || out_at[7:6] !== 2'b11) begin
            errors++;
            $display("FAIL conc_same_clk got at=%0d keyout=%h want at=%0d ch0=01 ch3=11",
                     both_at, out_at, 2 + CHK + LNG);
        end
    endtask

    task automatic test_reset_midhold();
        int rise_at = -1, evt_at = -1;
        logic [1:0] code_at_evt = 2'b00;
        for (int i = 0; i <= 2 + CHK + 20; i++) begin
            @(negedge clk);
            checks++;
            if ({keyout, key_evt, key_level} !== {m_code, m_evt, m_lvl}) begin
                errors++;
                $display("FAIL rmid_model i=%0d got=%h/%b/%b want=%h/%b/%b",
                         i, keyout, key_evt, key_level, m_code, m_evt, m_lvl);
            end
            keyin = raw(4'b0010);
        end
        checks++;
        if (key_level[1] !== 1'b1) begin
            errors++; $display("FAIL rmid_held got=%b want=1", key_level[1]);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({keyout, key_evt, key_level} !== '0) begin
            errors++; $display("FAIL rmid_async got=%h/%b/%b want=0/0/0", keyout, key_evt, key_level);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            checks++;
            if ({keyout, key_evt, key_level} !== {m_code, m_evt, m_lvl}) begin
                errors++;
                $display("FAIL rmid_model2 j=%0d got=%h/%b/%b want=%h/%b/%b",
                         j, keyout, key_evt, key_level, m_code, m_evt, m_lvl);
            end
            if (key_level[1] && rise_at < 0) rise_at = j;
            if (key_evt[1] && evt_at < 0) begin evt_at = j; code_at_evt = keyout[3:2]; end
        end
        checks++;
        if (rise_at != 2 + CHK || evt_at - rise_at != LNG || code_at_evt !== 2'b11) begin
            errors++;
            $display("FAIL rmid_fresh got rise=%0d evt=%0d code=%b want rise=%0d evt=%0d code=11",
                     rise_at, evt_at, code_at_evt, 2 + CHK, 2 + CHK + LNG);
        end
        keyin = raw('0);
        repeat (60) begin
            @(negedge clk);
            checks++;
            if ({keyout, key_evt, key_level} !== {m_code, m_evt, m_lvl}) begin
                errors++;
                $display("FAIL rmid_tail got=%h/%b/%b want=%h/%b/%b",
                         keyout, key_evt, key_level, m_code, m_evt, m_lvl);
            end
        end
    endtask

    task automatic test_random();
        int rem[NCH];
        logic [NCH-1:0] cur = '0;
        for (int c = 0; c < NCH; c++) rem[c] = $urandom_range(1, 45);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            checks++;
            if ({keyout, key_evt, key_level} !== {m_code, m_evt, m_lvl}) begin
                errors++;
                $display("FAIL random_model i=%0d got=%h/%b/%b want=%h/%b/%b",
                         i, keyout, key_evt, key_level, m_code, m_evt, m_lvl);
            end
            for (int c = 0; c < NCH; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    cur[c] = ~cur[c];
                    rem[c] = $urandom_range(1, 45);
                end
            end
            keyin = raw(i < 3900 ? cur : '0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        keyin = raw('0);
        test_reset();
        test_bounce();
        test_short();
        test_double();
        test_long();
        test_concurrency();
        test_reset_midhold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mkey_press.md
MKEY_PRESS -- requirements
Module: mkey_press

Interface
REQ-001 Parameter NCH, default 4: number of independent key channels, 1..16.
REQ-002 Parameter ISH, default 1'b0: 1 = raw key is pressed when high; 0 = pressed when low.
REQ-003 Parameter TICK_DIV, default 1: clk_100 cycles per timing tick, at least 1.
REQ-004 Parameter CHECKTIME, default 3: debounce threshold in ticks, at least 1.
REQ-005 Parameter LONGTIME, default 30: long-press threshold in ticks, greater than CHECKTIME.
REQ-006 Parameter DBLGAP, default 25: double-click window in ticks; 0 disables double-click detection.
REQ-007 Parameter OUTKEEP, default 2: event code hold time in ticks.
REQ-008 Port clk_100, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-009 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-010 Port keyin, input, NCH bits: raw, asynchronous key inputs, one per channel.
REQ-011 Port keyout, output, 2*NCH bits: channel c event code in bits [2c+1:2c]. Codes: 00 none, 01 short, 10 double, 11 long.
REQ-012 Port key_evt, output, NCH bits: one-clk pulse per channel when a new code is loaded.
REQ-013 Port key_level, output, NCH bits: debounced pressed level, 1 = pressed.

Function
REQ-014 Tick prescaler shall count 0..TICK_DIV-1 and assert tick for one clk at TICK_DIV-1. With TICK_DIV=1, tick is high every clk. The prescaler is shared by all channels.
REQ-015 Each keyin bit shall pass a 2-flop synchronizer. Pressed = ISH ? sync : ~sync.
REQ-016 key_level shall toggle only after pressed differs from key_level on CHECKTIME consecutive ticks. Any tick with agreement shall clear the filter count.
REQ-017 Each channel shall run a classifier FSM on key_level edges, with states IDLE, HELD, GAP, SECOND, LONG_WAIT.
REQ-018 IDLE: on the rising edge of key_level, go to HELD with hold count 0.
REQ-019 HELD: hold count increments per tick.
  - Reaching LONGTIME emits LONG and goes to LONG_WAIT.
  - Release before LONGTIME with DBLGAP=0 emits SHORT and goes to IDLE.
  - Release before LONGTIME with DBLGAP>0 goes to GAP with gap count 0.
REQ-020 GAP: gap count increments per tick.
  - A press edge goes to SECOND with hold count 0.
  - Gap count reaching DBLGAP emits SHORT and goes to IDLE.
  - A press edge and DBLGAP expiry in the same clk resolve as the press edge.
REQ-021 SECOND: release emits DOUBLE and goes to IDLE. Hold count reaching LONGTIME emits LONG (first click discarded) and goes to LONG_WAIT.
REQ-022 LONG_WAIT: no events; release goes to IDLE.
REQ-023 Emit behaviour:
  - Load the code into the channel's keyout slot and pulse key_evt for exactly one clk.
  - Hold the code for OUTKEEP ticks after the emit, then return it to 00.
  - OUTKEEP=0 holds the code for exactly the emit clk plus one.
REQ-024 A new event during the hold shall overwrite the code, pulse key_evt, and restart the hold.
REQ-025 Channels shall be fully independent. Simultaneous events on several channels shall all be reported in the same clk.
REQ-026 All counters shall saturate and never wrap. Counter widths are derived with $clog2 from the parameters.

Reset
REQ-027 rst_n low shall immediately force keyout=0, key_evt=0, key_level=0, all FSMs to IDLE, all counters to 0, and the synchronizers to the released value.
REQ-028 After a reset release with a key already held, the press shall be seen as a fresh press after CHECKTIME ticks. No event shall be emitted from pre-reset history.

Verification
All scenarios use default parameters and TICK_DIV=1 unless noted.
REQ-029 Bounce: ch0 pressed 2 clk / released 2 clk, repeated 10 times -> key_level[0] stays 0, no key_evt.
REQ-030 Short press: ch1 pressed 10 clk, then released.
  - key_level[1] rises 5 clk after the press (2 sync + 3 debounce).
  - keyout[3:2]=01 with a single key_evt[1] pulse 25 ticks after key_level falls.
  - keyout[3:2] returns to 00 two ticks later.
REQ-031 Double: ch0 press 8 / release 10 / press 8 / release -> keyout[1:0]=10 on the second key_level fall. No 01 is ever emitted.
REQ-032 Long: ch2 held 50 clk -> keyout[5:4]=11 when the hold count reaches 30. Release emits nothing.
REQ-033 Concurrency: ch0 short and ch3 long with coinciding emit clk -> both codes and both key_evt bits appear in the same clk.
REQ-034 Reset mid-hold: assert rst_n low at hold count 20 on ch1 with the key still held.
  - Outputs go to 0 at once.
  - After release of rst_n: key_level[1] rises 5 clk later, and LONG is emitted 30 ticks after that.
